// File: rtl/id_stage_pkg.sv
// Shared constants, IF/ID register layout and small decode helpers for the
// instruction-decode stage.
package id_stage_pkg;

    localparam int WORD   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b
    } opcode_e;

    localparam logic [5:0] FN_JR = 6'h08;

    typedef struct packed {
        logic            valid;
        logic [WORD-1:0] pc;
        logic [WORD-1:0] instr;
    } ifid_t;

    function automatic logic [WORD-1:0] sext16(input logic [15:0] v);
        return {{(WORD-16){v[15]}}, v};
    endfunction

    // A producer writing r0 never creates a dependency.
    function automatic logic reg_hit(input logic [REG_AW-1:0] dest,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt,
                                     input logic              check_rt);
        return (dest != '0) && ((dest == rs) || (check_rt && (dest == rt)));
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Signal bundle around the decode stage: fetch in/out, write-back, EX/MEM
// hazard inputs and decoded operands to EX.
interface id_stage_if;
    import id_stage_pkg::*;

    logic [WORD-1:0]   if_pc;
    logic [WORD-1:0]   if_instruction;
    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [WORD-1:0]   wb_data;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_dest;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic [REG_AW-1:0] mem_dest;
    logic [WORD-1:0]   mem_result;
    logic              branch_taken;
    logic              jump_taken;
    logic [WORD-1:0]   branch_offset;
    logic [WORD-1:0]   new_addr;
    logic              stall;
    logic              id_valid;
    logic [WORD-1:0]   id_pc;
    logic [WORD-1:0]   id_instruction;
    logic [WORD-1:0]   rs_val;
    logic [WORD-1:0]   rt_val;
    logic [WORD-1:0]   imm_ext;
    logic [WORD-1:0]   link_val;

    // Surrounding pipeline drives the stage.
    modport master (
        output if_pc, if_instruction, wb_we, wb_addr, wb_data,
               ex_reg_write, ex_mem_read, ex_dest,
               mem_reg_write, mem_mem_read, mem_dest, mem_result,
        input  branch_taken, jump_taken, branch_offset, new_addr, stall,
               id_valid, id_pc, id_instruction, rs_val, rt_val, imm_ext, link_val
    );

    modport slave (
        input  if_pc, if_instruction, wb_we, wb_addr, wb_data,
               ex_reg_write, ex_mem_read, ex_dest,
               mem_reg_write, mem_mem_read, mem_dest, mem_result,
        output branch_taken, jump_taken, branch_offset, new_addr, stall,
               id_valid, id_pc, id_instruction, rs_val, rt_val, imm_ext, link_val
    );

endinterface

// File: rtl/id_stage_reg_file.sv
// 32 x WORD register file: two combinational read ports with write-to-read
// bypass, one write port, r0 hardwired to zero.
module id_stage_reg_file
    import id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [WORD-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    output logic [WORD-1:0]   rdata_a_o,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [WORD-1:0]   rdata_b_o
);

    logic [WORD-1:0] regs_q [NREGS];

    // NOTE: the whole array is cleared on reset because software relies on
    // every register reading 0 afterwards; that forces flops, not a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0)                ? '0      :
                       (we_i && (waddr_i == raddr_a_i)) ? wdata_i :
                                                          regs_q[raddr_a_i];

    assign rdata_b_o = (raddr_b_i == '0)                ? '0      :
                       (we_i && (waddr_i == raddr_b_i)) ? wdata_i :
                                                          regs_q[raddr_b_i];

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file, hazard detection and early
// resolution of beq/bne/j/jal/jr with MEM-to-comparator forwarding.
module id_stage
    import id_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    id_stage_if.slave bus
);

    ifid_t ifid_q, ifid_d;

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [WORD-1:0]   rs_rd;
    logic [WORD-1:0]   rt_rd;
    logic [WORD-1:0]   imm;

    assign op    = ifid_q.instr[31:26];
    assign rs    = ifid_q.instr[25:21];
    assign rt    = ifid_q.instr[20:16];
    assign funct = ifid_q.instr[5:0];
    assign imm   = sext16(ifid_q.instr[15:0]);

    id_stage_reg_file u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .we_i      (bus.wb_we),
        .waddr_i   (bus.wb_addr),
        .wdata_i   (bus.wb_data),
        .raddr_a_i (rs),
        .rdata_a_o (rs_rd),
        .raddr_b_i (rt),
        .rdata_b_o (rt_rd)
    );

    logic is_beq, is_bne, is_branch, is_jump, is_jr, redirect_op, uses_rt;

    assign is_beq      = (op == OP_BEQ);
    assign is_bne      = (op == OP_BNE);
    assign is_branch   = is_beq || is_bne;
    assign is_jump     = (op == OP_J) || (op == OP_JAL);
    assign is_jr       = (op == OP_RTYPE) && (funct == FN_JR);
    assign redirect_op = is_branch || is_jr;
    assign uses_rt     = is_branch || (op == OP_RTYPE) || (op == OP_SW);

    logic load_use, ex_cmp_hazard, mem_load_hazard, stall;

    // The comparator resolves in ID, so an EX producer or a MEM load cannot
    // reach it in time; ordinary consumers only care about loads in EX.
    assign load_use        = bus.ex_mem_read && reg_hit(bus.ex_dest, rs, rt, uses_rt);
    assign ex_cmp_hazard   = redirect_op && bus.ex_reg_write
                             && reg_hit(bus.ex_dest, rs, rt, is_branch);
    assign mem_load_hazard = redirect_op && bus.mem_mem_read
                             && reg_hit(bus.mem_dest, rs, rt, is_branch);
    assign stall           = ifid_q.valid && (load_use || ex_cmp_hazard || mem_load_hazard);

    logic            fwd_ok;
    logic [WORD-1:0] cmp_a, cmp_b;

    assign fwd_ok = bus.mem_reg_write && !bus.mem_mem_read;
    assign cmp_a  = (fwd_ok && reg_hit(bus.mem_dest, rs, rs, 1'b0)) ? bus.mem_result : rs_rd;
    assign cmp_b  = (fwd_ok && reg_hit(bus.mem_dest, rt, rt, 1'b0)) ? bus.mem_result : rt_rd;

    logic            go, branch_taken, jump_taken;
    logic [WORD-1:0] jump_target;

    assign go           = ifid_q.valid && !stall;
    assign branch_taken = go && ((is_beq && (cmp_a == cmp_b)) || (is_bne && (cmp_a != cmp_b)));
    assign jump_taken   = go && (is_jump || is_jr);
    assign jump_target  = is_jr ? cmp_a : {ifid_q.pc[31:28], ifid_q.instr[25:0], 2'b00};

    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        ifid_d = ifid_q;
        if (!stall) begin
            if (branch_taken || jump_taken) begin
                ifid_d.valid = 1'b0;
                ifid_d.instr = '0;
            end else begin
                ifid_d = '{valid: 1'b1, pc: bus.if_pc, instr: bus.if_instruction};
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q <= '0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign bus.branch_taken   = branch_taken;
    assign bus.jump_taken     = jump_taken;
    assign bus.branch_offset  = ifid_q.valid ? imm : '0;
    assign bus.new_addr       = jump_taken ? jump_target : '0;
    assign bus.stall          = stall;
    assign bus.id_valid       = go;
    assign bus.id_pc          = ifid_q.pc;
    assign bus.id_instruction = ifid_q.instr;
    assign bus.rs_val         = rs_rd;
    assign bus.rt_val         = rt_rd;
    assign bus.imm_ext        = imm;
    assign bus.link_val       = ifid_q.pc + WORD'(4);

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by randomized
// traffic compared against a behavioural model of the decode stage.
module tb_id_stage;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        valid;
        logic        bt;
        logic        jt;
        logic [31:0] off;
        logic [31:0] naddr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [31:0] link;
    } exp_t;

    // Architectural model: IF/ID contents and register file contents.
    logic        m_valid = 1'b0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_rf [32];

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] fn);
        return {6'd0, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
        return m_rf[a];
    endfunction

    function automatic exp_t model_out();
        exp_t        e;
        logic [5:0]  op, fn;
        logic [4:0]  s, t;
        logic        is_br, is_jr, is_j, uses_t, haz;
        logic [31:0] a, b, imm;
        op     = m_instr[31:26];
        fn     = m_instr[5:0];
        s      = m_instr[25:21];
        t      = m_instr[20:16];
        is_br  = (op == 6'd4) || (op == 6'd5);
        is_jr  = (op == 6'd0) && (fn == 6'd8);
        is_j   = (op == 6'd2) || (op == 6'd3);
        uses_t = is_br || (op == 6'd0) || (op == 6'h2b);
        haz    = 1'b0;
        if (bus.ex_mem_read && bus.ex_dest != 0 &&
            (bus.ex_dest == s || (uses_t && bus.ex_dest == t))) haz = 1'b1;
        if ((is_br || is_jr) && bus.ex_reg_write && bus.ex_dest != 0 &&
            (bus.ex_dest == s || (is_br && bus.ex_dest == t))) haz = 1'b1;
        if ((is_br || is_jr) && bus.mem_mem_read && bus.mem_dest != 0 &&
            (bus.mem_dest == s || (is_br && bus.mem_dest == t))) haz = 1'b1;
        a = (bus.mem_reg_write && !bus.mem_mem_read && bus.mem_dest != 0 && bus.mem_dest == s)
            ? bus.mem_result : m_rd(s);
        b = (bus.mem_reg_write && !bus.mem_mem_read && bus.mem_dest != 0 && bus.mem_dest == t)
            ? bus.mem_result : m_rd(t);
        imm     = 32'(int'($signed(m_instr[15:0])));
        e.stall = m_valid && haz;
        e.valid = m_valid && !e.stall;
        e.bt    = e.valid && ((op == 6'd4 && a == b) || (op == 6'd5 && a != b));
        e.jt    = e.valid && (is_j || is_jr);
        e.naddr = !e.jt ? 32'd0 : is_jr ? a : (m_pc & 32'hF000_0000) | (32'(m_instr[25:0]) * 4);
        e.off   = m_valid ? imm : 32'd0;
        e.rs    = m_rd(s);
        e.rt    = m_rd(t);
        e.imm   = imm;
        e.link  = m_pc + 32'd4;
        return e;
    endfunction

    // Advance one clock; the model follows the same edge.
    task automatic tick();
        exp_t e;
        e = model_out();
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_pc    = '0;
            m_instr = '0;
            foreach (m_rf[i]) m_rf[i] = '0;
        end else begin
            if (bus.wb_we && bus.wb_addr != 0) m_rf[bus.wb_addr] = bus.wb_data;
            if (!e.stall) begin
                if (e.bt || e.jt) begin
                    m_valid = 1'b0;
                    m_instr = '0;
                end else begin
                    m_valid = 1'b1;
                    m_pc    = bus.if_pc;
                    m_instr = bus.if_instruction;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        bus.if_pc          = '0;
        bus.if_instruction = '0;
        bus.wb_we          = 1'b0;
        bus.wb_addr        = '0;
        bus.wb_data        = '0;
        bus.ex_reg_write   = 1'b0;
        bus.ex_mem_read    = 1'b0;
        bus.ex_dest        = '0;
        bus.mem_reg_write  = 1'b0;
        bus.mem_mem_read   = 1'b0;
        bus.mem_dest       = '0;
        bus.mem_result     = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        bus.if_pc          = 32'h40;
        bus.if_instruction = enc_j(6'd2, 26'h123);
        tick();
        tick();
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", bus.id_valid); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", bus.stall); end
        checks++; if (bus.jump_taken !== 1'b0) begin failures++; $display("FAIL reset_jump got=%0h exp=0", bus.jump_taken); end
        checks++; if (bus.new_addr !== 32'd0) begin failures++; $display("FAIL reset_new_addr got=%0h exp=0", bus.new_addr); end
        checks++; if (bus.id_instruction !== 32'd0) begin failures++; $display("FAIL reset_instr got=%0h exp=0", bus.id_instruction); end
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_beq_taken();
        idle();
        bus.wb_we = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'd5;
        tick();
        bus.wb_addr = 5'd2;
        tick();
        idle();
        bus.if_pc = 32'h10; bus.if_instruction = enc_i(6'd4, 5'd1, 5'd2, 16'd3);
        tick();
        bus.if_pc = 32'h14; bus.if_instruction = enc_r(5'd1, 5'd2, 5'd9, 6'd32);
        @(negedge clk);
        checks++; if (bus.branch_taken !== 1'b1) begin failures++; $display("FAIL beq_taken got=%0h exp=1", bus.branch_taken); end
        checks++; if (bus.branch_offset !== 32'd3) begin failures++; $display("FAIL beq_offset got=%0h exp=3", bus.branch_offset); end
        checks++; if (bus.if_pc + (bus.branch_offset << 2) !== 32'h20) begin failures++; $display("FAIL beq_next_pc got=%0h exp=20", bus.if_pc + (bus.branch_offset << 2)); end
        tick();
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL beq_flush_valid got=%0h exp=0", bus.id_valid); end
        checks++; if (bus.id_instruction !== 32'd0) begin failures++; $display("FAIL beq_flush_instr got=%0h exp=0", bus.id_instruction); end
        idle();
        tick();
    endtask

    task automatic test_load_use();
        logic [31:0] add_i;
        add_i = enc_r(5'd3, 5'd3, 5'd4, 6'd32);
        idle();
        bus.if_pc = 32'h20; bus.if_instruction = add_i;
        tick();
        bus.if_pc = 32'h24; bus.if_instruction = '0;
        bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dest = 5'd3;
        @(negedge clk);
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL load_use_stall got=%0h exp=1", bus.stall); end
        checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL load_use_bubble got=%0h exp=0", bus.id_valid); end
        tick();
        bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_dest = '0;
        @(negedge clk);
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL load_use_release got=%0h exp=0", bus.stall); end
        checks++; if (bus.id_valid !== 1'b1) begin failures++; $display("FAIL load_use_redecode got=%0h exp=1", bus.id_valid); end
        checks++; if (bus.id_instruction !== add_i || bus.id_pc !== 32'h20) begin failures++; $display("FAIL load_use_hold got=%0h/%0h exp=%0h/20", bus.id_instruction, bus.id_pc, add_i); end
        idle();
        tick();
    endtask

    task automatic test_bne_forward();
        logic [31:0] bne_i;
        bne_i = enc_i(6'd5, 5'd5, 5'd0, 16'd2);
        idle();
        bus.if_pc = 32'h30; bus.if_instruction = bne_i;
        tick();
        bus.if_instruction = '0;
        bus.mem_reg_write = 1'b1; bus.mem_dest = 5'd5; bus.mem_result = 32'd7;
        @(negedge clk);
        checks++; if (bus.branch_taken !== 1'b1 || bus.stall !== 1'b0) begin failures++; $display("FAIL bne_fwd_mem got=%0h/%0h exp=1/0", bus.branch_taken, bus.stall); end
        tick();
        idle();
        bus.if_pc = 32'h30; bus.if_instruction = bne_i;
        tick();
        bus.if_instruction = '0;
        bus.ex_reg_write = 1'b1; bus.ex_dest = 5'd5;
        @(negedge clk);
        checks++; if (bus.stall !== 1'b1 || bus.branch_taken !== 1'b0) begin failures++; $display("FAIL bne_ex_stall got=%0h/%0h exp=1/0", bus.stall, bus.branch_taken); end
        tick();
        bus.ex_reg_write = 1'b0; bus.ex_dest = '0;
        bus.mem_reg_write = 1'b1; bus.mem_dest = 5'd5; bus.mem_result = 32'd7;
        @(negedge clk);
        checks++; if (bus.branch_taken !== 1'b1 || bus.stall !== 1'b0) begin failures++; $display("FAIL bne_after_stall got=%0h/%0h exp=1/0", bus.branch_taken, bus.stall); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_jumps();
        idle();
        bus.if_pc = 32'h1000_0008; bus.if_instruction = enc_j(6'd2, 26'h40);
        tick();
        bus.if_instruction = '0;
        @(negedge clk);
        checks++; if (bus.jump_taken !== 1'b1 || bus.new_addr !== 32'h1000_0100) begin failures++; $display("FAIL j_target got=%0h/%0h exp=1/10000100", bus.jump_taken, bus.new_addr); end
        tick();
        bus.wb_we = 1'b1; bus.wb_addr = 5'd31; bus.wb_data = 32'h44;
        tick();
        idle();
        bus.if_pc = 32'h50; bus.if_instruction = enc_r(5'd31, 5'd0, 5'd0, 6'd8);
        tick();
        bus.if_instruction = '0;
        @(negedge clk);
        checks++; if (bus.jump_taken !== 1'b1 || bus.new_addr !== 32'h44) begin failures++; $display("FAIL jr_target got=%0h/%0h exp=1/44", bus.jump_taken, bus.new_addr); end
        tick();
        bus.if_pc = 32'h60; bus.if_instruction = enc_j(6'd3, 26'h10);
        tick();
        bus.if_instruction = '0;
        @(negedge clk);
        checks++; if (bus.new_addr !== 32'h40 || bus.link_val !== 32'h64) begin failures++; $display("FAIL jal_target_link got=%0h/%0h exp=40/64", bus.new_addr, bus.link_val); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_regfile_bypass();
        idle();
        bus.if_pc = 32'h70; bus.if_instruction = enc_r(5'd7, 5'd0, 5'd8, 6'd32);
        tick();
        bus.wb_we = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'hDEAD;
        @(negedge clk);
        checks++; if (bus.rs_val !== 32'hDEAD) begin failures++; $display("FAIL wb_bypass got=%0h exp=dead", bus.rs_val); end
        tick();
        bus.wb_we = 1'b0;
        @(negedge clk);
        checks++; if (bus.rs_val !== 32'hDEAD) begin failures++; $display("FAIL wb_stored got=%0h exp=dead", bus.rs_val); end
        bus.if_instruction = enc_r(5'd0, 5'd0, 5'd8, 6'd32);
        tick();
        bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1234;
        @(negedge clk);
        checks++; if (bus.rs_val !== 32'd0) begin failures++; $display("FAIL r0_bypass got=%0h exp=0", bus.rs_val); end
        tick();
        bus.wb_we = 1'b0;
        @(negedge clk);
        checks++; if (bus.rs_val !== 32'd0) begin failures++; $display("FAIL r0_stored got=%0h exp=0", bus.rs_val); end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_stall();
        idle();
        bus.if_pc = 32'h80; bus.if_instruction = enc_i(6'd4, 5'd1, 5'd2, 16'd1);
        tick();
        bus.if_instruction = '0;
        bus.ex_reg_write = 1'b1; bus.ex_dest = 5'd1;
        @(negedge clk);
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL rst_stall_pre got=%0h exp=1", bus.stall); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b0 || bus.stall !== 1'b0 || bus.branch_taken !== 1'b0) begin failures++; $display("FAIL rst_stall_post got=%0h/%0h/%0h exp=0/0/0", bus.id_valid, bus.stall, bus.branch_taken); end
        idle();
        bus.if_instruction = enc_r(5'd1, 5'd2, 5'd8, 6'd32);
        tick();
        @(negedge clk);
        checks++; if (bus.rs_val !== 32'd0 || bus.rt_val !== 32'd0) begin failures++; $display("FAIL rst_regs_clear got=%0h/%0h exp=0/0", bus.rs_val, bus.rt_val); end
        idle();
        tick();
    endtask

    function automatic logic [4:0] rand_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    function automatic logic [31:0] rand_data();
        return $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : 32'($urandom());
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [15:0] imm;
        imm = 16'($urandom());
        case ($urandom_range(0, 8))
            0:       return enc_i(6'd4, rand_reg(), rand_reg(), imm);
            1:       return enc_i(6'd5, rand_reg(), rand_reg(), imm);
            2:       return enc_j(6'd2, 26'($urandom()));
            3:       return enc_j(6'd3, 26'($urandom()));
            4:       return enc_r(rand_reg(), 5'd0, 5'd0, 6'd8);
            5:       return enc_r(rand_reg(), rand_reg(), rand_reg(), 6'd32);
            6:       return enc_i(6'h23, rand_reg(), rand_reg(), imm);
            7:       return enc_i(6'h2b, rand_reg(), rand_reg(), imm);
            default: return enc_i(6'h08, rand_reg(), rand_reg(), imm);
        endcase
    endfunction

    task automatic test_random();
        exp_t e;
        for (int n = 0; n < 600; n++) begin
            rst                = ($urandom_range(0, 49) == 0);
            bus.if_pc          = $urandom() & 32'hFFFF_FFFC;
            bus.if_instruction = rand_instr();
            bus.wb_we          = 1'($urandom_range(0, 1));
            bus.wb_addr        = rand_reg();
            bus.wb_data        = rand_data();
            bus.ex_reg_write   = 1'($urandom_range(0, 1));
            bus.ex_mem_read    = ($urandom_range(0, 3) == 0);
            bus.ex_dest        = rand_reg();
            bus.mem_reg_write  = 1'($urandom_range(0, 1));
            bus.mem_mem_read   = ($urandom_range(0, 3) == 0);
            bus.mem_dest       = rand_reg();
            bus.mem_result     = rand_data();
            @(negedge clk);
            e = model_out();
            checks++; if (bus.stall !== e.stall) begin failures++; $display("FAIL rand_stall n=%0d got=%0h exp=%0h", n, bus.stall, e.stall); end
            checks++; if (bus.id_valid !== e.valid) begin failures++; $display("FAIL rand_valid n=%0d got=%0h exp=%0h", n, bus.id_valid, e.valid); end
            checks++; if (bus.branch_taken !== e.bt) begin failures++; $display("FAIL rand_branch n=%0d got=%0h exp=%0h", n, bus.branch_taken, e.bt); end
            checks++; if (bus.jump_taken !== e.jt) begin failures++; $display("FAIL rand_jump n=%0d got=%0h exp=%0h", n, bus.jump_taken, e.jt); end
            checks++; if (bus.branch_offset !== e.off) begin failures++; $display("FAIL rand_offset n=%0d got=%0h exp=%0h", n, bus.branch_offset, e.off); end
            checks++; if (bus.new_addr !== e.naddr) begin failures++; $display("FAIL rand_new_addr n=%0d got=%0h exp=%0h", n, bus.new_addr, e.naddr); end
            checks++; if (bus.rs_val !== e.rs) begin failures++; $display("FAIL rand_rs n=%0d got=%0h exp=%0h", n, bus.rs_val, e.rs); end
            checks++; if (bus.rt_val !== e.rt) begin failures++; $display("FAIL rand_rt n=%0d got=%0h exp=%0h", n, bus.rt_val, e.rt); end
            checks++; if (bus.imm_ext !== e.imm) begin failures++; $display("FAIL rand_imm n=%0d got=%0h exp=%0h", n, bus.imm_ext, e.imm); end
            checks++; if (bus.link_val !== e.link) begin failures++; $display("FAIL rand_link n=%0d got=%0h exp=%0h", n, bus.link_val, e.link); end
            checks++; if (bus.id_instruction !== m_instr) begin failures++; $display("FAIL rand_instr n=%0d got=%0h exp=%0h", n, bus.id_instruction, m_instr); end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        foreach (m_rf[i]) m_rf[i] = '0;
        idle();
        #1;
        test_reset();
        test_beq_taken();
        test_load_use();
        test_bne_forward();
        test_jumps();
        test_regfile_bypass();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
